// File: rtl/apb_sched_pkg.sv
// Shared types and bus widths for the APB request scheduler slice.
// Widths mirror the apb_bridge command side (32-bit address/data, byte strobes).
package apb_sched_pkg;

  localparam int unsigned ADDR_WIDTH = 32;
  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned STRB_SIZE  = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } sched_state_e;

  typedef struct packed {
    logic                  wr;
    logic [STRB_SIZE-1:0]  strb;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } apb_cmd_t;

endpackage

// File: rtl/apb_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searching from a registered
// pointer; on advance the pointer moves to one past the served requester.
module apb_rr_arbiter #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req_i,
  input  logic            advance_i,
  input  logic [IW-1:0]   adv_idx_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IW-1:0]   idx_o
);

  logic [IW-1:0] ptr_q;

  always_comb begin
    automatic logic        found = 1'b0;
    automatic int unsigned c     = 0;
    gnt_o = '0;
    idx_o = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      c = (32'(ptr_q) + k) % NREQ;
      if (!found && req_i[c]) begin
        found    = 1'b1;
        gnt_o[c] = 1'b1;
        idx_o    = IW'(c);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (advance_i) begin
      ptr_q <= (adv_idx_i == IW'(NREQ - 1)) ? '0 : adv_idx_i + 1'b1;
    end
  end

endmodule

// File: rtl/apb_req_sched.sv
// Round-robin scheduler sharing one apb_bridge command port among NREQ requesters.
// Optional BUSY-timeout abort is enabled by defining APB_SCHED_TIMEOUT_EN.
import apb_sched_pkg::*;

module apb_req_sched #(
  parameter int unsigned NREQ        = 2,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NREQ-1:0]                      req_valid,
  input  logic [NREQ-1:0]                      req_wr,
  input  logic [NREQ-1:0][STRB_SIZE-1:0]       req_strb,
  input  logic [NREQ-1:0][ADDR_WIDTH-1:0]      req_addr,
  input  logic [NREQ-1:0][DATA_WIDTH-1:0]      req_wdata,
  output logic [NREQ-1:0]                      req_ready,
  output logic [NREQ-1:0]                      rsp_valid,
  output logic [DATA_WIDTH-1:0]                rsp_rdata,
  output logic                                 rsp_err,
  output logic                                 br_trnsfr,
  output logic                                 br_wr,
  output logic [STRB_SIZE-1:0]                 br_strb,
  output logic [ADDR_WIDTH-1:0]                br_address,
  output logic [DATA_WIDTH-1:0]                br_data_in,
  input  logic [DATA_WIDTH-1:0]                br_data_out,
  input  logic                                 br_done
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  if (NREQ < 2 || TIMEOUT_CYC < 1) begin : g_cfg_check
    $error("apb_req_sched: NREQ must be >= 2 and TIMEOUT_CYC >= 1");
  end

  sched_state_e          state_q;
  apb_cmd_t              cmd_q;
  logic [IW-1:0]         gidx_q;
  logic [NREQ-1:0]       req_ready_q;
  logic [NREQ-1:0]       rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic                  br_trnsfr_q;

  logic [NREQ-1:0]       arb_gnt;
  logic [IW-1:0]         arb_idx;
  logic                  advance;
  logic [NREQ-1:0]       gidx_onehot;

  assign advance     = (state_q == RESP);
  assign gidx_onehot = NREQ'(1) << gidx_q;

  apb_rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (req_valid),
    .advance_i (advance),
    .adv_idx_i (gidx_q),
    .gnt_o     (arb_gnt),
    .idx_o     (arb_idx)
  );

`ifdef APB_SCHED_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] tcnt_q;
  logic [CW-1:0] tcnt_d;
  logic          rsp_err_q;
  logic          timeout;

  assign tcnt_d  = tcnt_q + 1'b1;
  assign timeout = (tcnt_d == CW'(TIMEOUT_CYC));
  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cmd_q       <= '0;
      gidx_q      <= '0;
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      br_trnsfr_q <= 1'b0;
`ifdef APB_SCHED_TIMEOUT_EN
      tcnt_q      <= '0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      unique case (state_q)
        IDLE: begin
          if (|req_valid) begin
            cmd_q.wr    <= req_wr[arb_idx];
            cmd_q.strb  <= req_strb[arb_idx];
            cmd_q.addr  <= req_addr[arb_idx];
            cmd_q.wdata <= req_wdata[arb_idx];
            gidx_q      <= arb_idx;
            req_ready_q <= arb_gnt;
            br_trnsfr_q <= 1'b1;
            state_q     <= BUSY;
`ifdef APB_SCHED_TIMEOUT_EN
            tcnt_q      <= '0;
`endif
          end
        end
        BUSY: begin
          // br_done takes precedence over a timeout landing in the same cycle
          if (br_done) begin
            rsp_valid_q <= gidx_onehot;
            rsp_rdata_q <= cmd_q.wr ? '0 : br_data_out;
            br_trnsfr_q <= 1'b0;
            state_q     <= RESP;
`ifdef APB_SCHED_TIMEOUT_EN
            rsp_err_q   <= 1'b0;
          end else if (timeout) begin
            rsp_valid_q <= gidx_onehot;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b1;
            br_trnsfr_q <= 1'b0;
            state_q     <= RESP;
          end else begin
            tcnt_q      <= tcnt_d;
`endif
          end
        end
        RESP: begin
          rsp_rdata_q <= '0;
`ifdef APB_SCHED_TIMEOUT_EN
          rsp_err_q   <= 1'b0;
`endif
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign br_trnsfr  = br_trnsfr_q;
  assign br_wr      = cmd_q.wr;
  assign br_strb    = cmd_q.strb;
  assign br_address = cmd_q.addr;
  assign br_data_in = cmd_q.wdata;

endmodule

// File: tb/tb_apb_req_sched.sv
// Scoreboard bench for apb_req_sched: stimulus pushes expected grants/responses,
// a negedge monitor pops and compares whenever req_ready or rsp_valid fires.
module tb_apb_req_sched;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [1:0]        req_valid;
  logic [1:0]        req_wr;
  logic [1:0][3:0]   req_strb;
  logic [1:0][31:0]  req_addr;
  logic [1:0][31:0]  req_wdata;
  logic [1:0]        req_ready;
  logic [1:0]        rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic              br_trnsfr;
  logic              br_wr;
  logic [3:0]        br_strb;
  logic [31:0]       br_address;
  logic [31:0]       br_data_in;
  logic [31:0]       br_data_out;
  logic              br_done;

  apb_req_sched #(
    .NREQ        (2),
    .TIMEOUT_CYC (64)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_wr      (req_wr),
    .req_strb    (req_strb),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .br_trnsfr   (br_trnsfr),
    .br_wr       (br_wr),
    .br_strb     (br_strb),
    .br_address  (br_address),
    .br_data_in  (br_data_in),
    .br_data_out (br_data_out),
    .br_done     (br_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic        wr;
    logic [3:0]  strb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } exp_cmd_t;

  typedef struct {
    int          idx;
    logic [31:0] rdata;
    logic        err;
  } exp_rsp_t;

  exp_cmd_t cmd_q[$];
  exp_rsp_t rsp_q[$];
  int checks = 0;
  int errors = 0;

  // bridge model
  bit          br_en  = 1'b1;
  int          br_dly = 3;
  logic [31:0] br_rdata = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    int  bcnt = 0;
    bit  sent = 0;
    br_done = 1'b0;
    forever begin
      @(negedge clk);
      br_done     = 1'b0;
      br_data_out = br_rdata;
      if (!br_trnsfr) begin
        bcnt = 0;
        sent = 0;
      end else if (br_en && !sent) begin
        bcnt++;
        if (bcnt == br_dly) begin
          br_done = 1'b1;
          sent    = 1;
        end
      end
    end
  end

  // monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (|req_ready) begin
        if (cmd_q.size() == 0) begin
          chk("unexpected_req_ready", 64'(req_ready), 64'd0);
        end else begin
          exp_cmd_t e;
          e = cmd_q.pop_front();
          chk("req_ready_grant", 64'(req_ready), 64'(2'b01 << e.idx));
          chk("br_trnsfr_at_ready", 64'(br_trnsfr), 64'd1);
          chk("br_wr", 64'(br_wr), 64'(e.wr));
          chk("br_strb", 64'(br_strb), 64'(e.strb));
          chk("br_address", 64'(br_address), 64'(e.addr));
          chk("br_data_in", 64'(br_data_in), 64'(e.wdata));
        end
      end
      if (|rsp_valid) begin
        if (rsp_q.size() == 0) begin
          chk("unexpected_rsp_valid", 64'(rsp_valid), 64'd0);
        end else begin
          exp_rsp_t r;
          r = rsp_q.pop_front();
          chk("rsp_valid_idx", 64'(rsp_valid), 64'(2'b01 << r.idx));
          chk("rsp_rdata", 64'(rsp_rdata), 64'(r.rdata));
          chk("rsp_err", 64'(rsp_err), 64'(r.err));
        end
      end
    end
  end

  task automatic push_cmd(input int i, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] strb);
    exp_cmd_t e;
    e.idx = i; e.wr = wr; e.addr = addr; e.wdata = wdata; e.strb = strb;
    cmd_q.push_back(e);
  endtask

  task automatic push_rsp(input int i, input logic [31:0] rdata, input logic err);
    exp_rsp_t r;
    r.idx = i; r.rdata = rdata; r.err = err;
    rsp_q.push_back(r);
  endtask

  task automatic drive(input int i, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] strb);
    req_wr[i]    = wr;
    req_addr[i]  = addr;
    req_wdata[i] = wdata;
    req_strb[i]  = strb;
    req_valid[i] = 1'b1;
  endtask

  task automatic issue(input int i, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] strb, output int lat);
    push_cmd(i, wr, addr, wdata, strb);
    drive(i, wr, addr, wdata, strb);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!req_ready[i] && lat < 50);
    if (!req_ready[i]) chk("req_ready_wait_expired", 64'(lat), 64'd0);
    req_valid[i] = 1'b0;
  endtask

  task automatic drain(input int bound);
    int n = 0;
    while ((rsp_q.size() != 0 || cmd_q.size() != 0) && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (rsp_q.size() != 0 || cmd_q.size() != 0)
      chk("drain_wait_expired", 64'(rsp_q.size() + cmd_q.size()), 64'd0);
  endtask

  initial begin
    int lat;
    int n;
    bit stayed;
    rst_n     = 1'b0;
    req_valid = '0;
    req_wr    = '0;
    req_strb  = '0;
    req_addr  = '0;
    req_wdata = '0;
    repeat (2) @(negedge clk);
    chk("reset_req_ready", 64'(req_ready), 64'd0);
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_br_trnsfr", 64'(br_trnsfr), 64'd0);
    chk("reset_br_fields", {br_wr, br_strb, br_address[15:0], br_data_in}, 64'd0);
    chk("reset_rsp_data", {rsp_err, rsp_rdata}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: write from requester 0
    br_dly = 3;
    push_rsp(0, 32'h0, 1'b0);
    issue(0, 1'b1, 32'hA1, 32'hDEADBBEF, 4'hF, lat);
    chk("t1_ready_latency", 64'(lat), 64'd1);
    drain(30);

    // 2: read from requester 1
    br_rdata = 32'hDEADBBEF;
    push_rsp(1, 32'hDEADBBEF, 1'b0);
    issue(1, 1'b0, 32'hA1, 32'h0, 4'hF, lat);
    drain(30);

    // 3: both held, pointer at 0 -> 0,1,0,1
    br_rdata = 32'h12345678;
    br_dly   = 2;
    for (int k = 0; k < 2; k++) begin
      push_cmd(0, 1'b1, 32'h10, 32'h11111111, 4'h3);
      push_rsp(0, 32'h0, 1'b0);
      push_cmd(1, 1'b0, 32'h20, 32'hCAFEF00D, 4'hC);
      push_rsp(1, 32'h12345678, 1'b0);
    end
    drive(0, 1'b1, 32'h10, 32'h11111111, 4'h3);
    drive(1, 1'b0, 32'h20, 32'hCAFEF00D, 4'hC);
    n = 0;
    for (int c = 0; c < 100 && n < 4; c++) begin
      @(negedge clk);
      if (|rsp_valid) n++;
    end
    req_valid = '0;
    chk("t3_rsp_count", 64'(n), 64'd4);
    drain(30);

    // 4: reset while BUSY on requester 1, then contention goes to 0
    push_rsp(0, 32'h0, 1'b0);
    issue(0, 1'b1, 32'h30, 32'h0000BEEF, 4'h1, lat);
    drain(30);
    br_en = 1'b0;
    issue(1, 1'b1, 32'h40, 32'h44444444, 4'hF, lat);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t4_trnsfr_drops_async", 64'(br_trnsfr), 64'd0);
    chk("t4_rsp_valid_in_reset", 64'(rsp_valid), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    br_en = 1'b1;
    repeat (3) @(negedge clk);
    push_cmd(0, 1'b1, 32'h50, 32'h55555555, 4'h7);
    push_rsp(0, 32'h0, 1'b0);
    drive(0, 1'b1, 32'h50, 32'h55555555, 4'h7);
    drive(1, 1'b1, 32'h60, 32'h66666666, 4'hF);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (req_ready == '0 && n < 20);
    req_valid = '0;
    chk("t4_first_grant_after_reset", 64'(req_ready), 64'd1);
    drain(30);

    // 5/6: bridge never completes
    br_en = 1'b0;
`ifdef APB_SCHED_TIMEOUT_EN
    push_rsp(0, 32'h0, 1'b1);
    issue(0, 1'b0, 32'h70, 32'h0, 4'hF, lat);
    n = 1;
    for (int c = 0; c < 200 && br_trnsfr; c++) begin
      @(negedge clk);
      if (br_trnsfr) n++;
    end
    chk("t5_busy_cycles", 64'(n), 64'd64);
    drain(10);
`else
    issue(0, 1'b0, 32'h70, 32'h0, 4'hF, lat);
    stayed = 1'b1;
    repeat (100) begin
      @(negedge clk);
      if (!br_trnsfr || rsp_err) stayed = 1'b0;
    end
    chk("t6_trnsfr_held_no_err", 64'(stayed), 64'd1);
    chk("t6_no_rsp_valid", 64'(rsp_valid), 64'd0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
`endif
    br_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("end_cmd_queue_empty", 64'(cmd_q.size()), 64'd0);
    chk("end_rsp_queue_empty", 64'(rsp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
